// File: rtl/sobel_frame_ctrl.sv
// Frame-synchronous configuration scheduler for the Sobel pipeline: shadows CPU config
// requests, applies them at input start-of-frame, and gates output valid while old frames drain.
module sobel_frame_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int TIMEOUT    = 1048576
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic        cfg_update,
    input  logic        cfg_enable,
    input  logic        cfg_edge_select,
    input  logic [7:0]  cfg_threshold,
    input  logic [1:0]  cfg_kernel,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tuser,
    input  logic        m_axis_tvalid,
    input  logic        m_axis_tuser,
    input  logic        m_axis_tlast,
    output logic        enable,
    output logic        edge_select,
    output logic [7:0]  threshold,
    output logic [1:0]  kernel,
    output logic        g_axis_tvalid,
    output logic        g_axis_tuser,
    output logic        g_axis_tlast,
    output logic        cfg_busy,
    output logic        cfg_applied,
    output logic        drain_timeout,
    output logic [15:0] frame_cnt,
    output logic [1:0]  dbg_state
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(TIMEOUT - 1);

    // Frame geometry is informational only; reject nonsensical values at elaboration.
    if (IMG_WIDTH < 1 || IMG_HEIGHT < 1) begin : g_bad_geometry
        $error("sobel_frame_ctrl: IMG_WIDTH and IMG_HEIGHT must be positive");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_enable, r_edge_select, r_applied, r_timeout, r_pend;
    logic [7:0]      r_threshold;
    logic [1:0]      r_kernel;
    logic            r_sh_enable, r_sh_edge_select;
    logic [7:0]      r_sh_threshold;
    logic [1:0]      r_sh_kernel;
    logic [15:0]     r_frame_cnt;
    logic [CW-1:0]   r_drain_cnt;

    logic            w_isof, w_osof, w_open;
    logic [1:0]      w_cap_kernel;
    logic            w_load_shadow, w_apply, w_bypass, w_set_pend, w_exit, w_timeout;

    assign w_isof       = s_axis_tvalid & s_axis_tuser;
    assign w_osof       = m_axis_tvalid & m_axis_tuser;
    assign w_cap_kernel = (cfg_kernel == 2'b11) ? 2'b00 : cfg_kernel;

    always_comb begin
        w_next        = r_state;
        w_load_shadow = 1'b0;
        w_apply       = 1'b0;
        w_bypass      = 1'b0;
        w_set_pend    = 1'b0;
        w_exit        = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_update) begin
                    w_load_shadow = 1'b1;
                    w_next        = S_PENDING;
                end
            end
            S_PENDING: begin
                if (w_isof) begin
                    w_apply  = 1'b1;
                    w_bypass = cfg_update;
                    w_next   = S_DRAIN;
                end else if (cfg_update) begin
                    w_load_shadow = 1'b1;
                end
            end
            S_DRAIN: begin
                if (cfg_update) begin
                    w_load_shadow = 1'b1;
                    w_set_pend    = 1'b1;
                end
                // A first new-config frame emerging takes priority over the timeout.
                if (w_osof) begin
                    w_exit = 1'b1;
                end else if (r_drain_cnt == DRAIN_LAST) begin
                    w_exit    = 1'b1;
                    w_timeout = 1'b1;
                end
                if (w_exit) begin
                    w_next = (r_pend | cfg_update) ? S_PENDING : S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_enable         <= 1'b0;
            r_edge_select    <= 1'b0;
            r_threshold      <= 8'h00;
            r_kernel         <= 2'b00;
            r_sh_enable      <= 1'b0;
            r_sh_edge_select <= 1'b0;
            r_sh_threshold   <= 8'h00;
            r_sh_kernel      <= 2'b00;
            r_pend           <= 1'b0;
            r_applied        <= 1'b0;
            r_timeout        <= 1'b0;
            r_frame_cnt      <= 16'h0000;
            r_drain_cnt      <= '0;
        end else begin
            r_state     <= w_next;
            r_applied   <= w_apply;
            r_frame_cnt <= r_frame_cnt + {15'd0, w_isof};
            if (w_load_shadow) begin
                r_sh_enable      <= cfg_enable;
                r_sh_edge_select <= cfg_edge_select;
                r_sh_threshold   <= cfg_threshold;
                r_sh_kernel      <= w_cap_kernel;
            end
            if (w_apply) begin
                r_enable      <= w_bypass ? cfg_enable      : r_sh_enable;
                r_edge_select <= w_bypass ? cfg_edge_select : r_sh_edge_select;
                r_threshold   <= w_bypass ? cfg_threshold   : r_sh_threshold;
                r_kernel      <= w_bypass ? w_cap_kernel    : r_sh_kernel;
                r_drain_cnt   <= '0;
            end else if (r_state == S_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end
            if (w_exit) begin
                r_pend <= 1'b0;
            end else if (w_set_pend) begin
                r_pend <= 1'b1;
            end
            if (w_timeout) begin
                r_timeout <= 1'b1;
            end else if (cfg_update) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign w_open        = (r_state != S_DRAIN) | w_osof;
    assign g_axis_tvalid = m_axis_tvalid & w_open;
    assign g_axis_tuser  = m_axis_tuser & w_open;
    assign g_axis_tlast  = m_axis_tlast & w_open;

    assign enable        = r_enable;
    assign edge_select   = r_edge_select;
    assign threshold     = r_threshold;
    assign kernel        = r_kernel;
    assign cfg_busy      = (r_state != S_IDLE);
    assign cfg_applied   = r_applied;
    assign drain_timeout = r_timeout;
    assign frame_cnt     = r_frame_cnt;
    assign dbg_state     = r_state;
endmodule
